// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: slice width,
// FSM state type and slice-counter sizing.
package sub_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of the slice counter for a given operand width (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned n;
    n = width / SLICE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_sub4.sv
// 4-bit ripple-borrow subtractor built from full-subtractor cells.
// Purely combinational: d = a - b - b_in, b_out = borrow out of bit 3.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  // One-bit difference and borrow generation.
  always_comb begin
    d     = a ^ b ^ b_in;
    b_out = (~a & b) | (~(a ^ b) & b_in);
  end

endmodule

module subtractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       b_in,
  output logic [3:0] d,
  output logic       b_out
);

  logic [4:0] w_bchain;

  assign w_bchain[0] = b_in;
  assign b_out       = w_bchain[4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cell
      full_subtractor u_fs (
        .a     (a[gi]),
        .b     (b[gi]),
        .b_in  (w_bchain[gi]),
        .d     (d[gi]),
        .b_out (w_bchain[gi+1])
      );
    end
  endgenerate

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b over WIDTH bits, one 4-bit slice
// per clock with the borrow carried between slices in a flop.
// Handshake: start (sampled in IDLE), busy (RUN/DONE), done (1-cycle pulse).
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / SLICE_W;
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bflop;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [3:0]       w_slice_d;
  logic             w_slice_bout;
  logic [WIDTH-1:0] w_acc_next;

  subtractor_4bit u_slice (
    .a     (r_a[SLICE_W-1:0]),
    .b     (r_b[SLICE_W-1:0]),
    .b_in  (r_bflop),
    .d     (w_slice_d),
    .b_out (w_slice_bout)
  );

  // New slice enters at the top; after N shifts the first slice sits at bit 0.
  assign w_acc_next = {w_slice_d, r_acc[WIDTH-1:SLICE_W]};

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, slice shifting, borrow chaining and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_bflop  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bflop <= 1'b0;
    end else if (w_step) begin
      r_a     <= r_a >> SLICE_W;
      r_b     <= r_b >> SLICE_W;
      r_acc   <= w_acc_next;
      r_bflop <= w_slice_bout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff   <= w_acc_next;
        r_borrow <= w_slice_bout;
        r_ovf    <= (r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16).
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, borrow, ovf;
  logic [15:0] diff;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit abort = 1'b0;
  bit period_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_sub(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    logic [16:0] r;
    r    = {1'b0, x} - {1'b0, y};
    e.d  = r[15:0];
    e.bo = r[16];
    e.ov = (x[15] != y[15]) && (r[15] != x[15]);
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d = d; e.bo = bo; e.ov = ov; e.acc = 0;
    return e;
  endfunction

  // Monitor: checks results, latency, done width, busy length and period.
  bit prev_done = 1'b0;
  int blen = 0;
  int last_done = -1;
  always @(negedge clk) begin
    exp_t e;
    if (!period_on) last_done = -1;
    if (done) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("diff", {16'd0, diff}, {16'd0, e.d});
        chk("borrow", {31'd0, borrow}, {31'd0, e.bo});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
        chk("latency", cyc - e.acc, 32'd4);
      end
      if (period_on) begin
        if (last_done >= 0) chk("done_period", cyc - last_done, 32'd6);
        last_done = cyc;
      end
    end
    prev_done = done;
    if (busy) begin
      blen++;
    end else begin
      if (blen != 0) begin
        if (abort) abort = 1'b0;
        else chk("busy_len", blen, 32'd5);
      end
      blen = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
    wait_idle();
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input exp_t e);
    wait_idle();
    a = x;
    b = y;
    start = 1'b1;
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] x, y;
    exp_t e;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, hand-computed
    issue(16'h1234, 16'h0234, mk(16'h1000, 1'b0, 1'b0));
    issue(16'h0000, 16'h0001, mk(16'hFFFF, 1'b1, 1'b0));
    issue(16'h0F0F, 16'h0F0F, mk(16'h0000, 1'b0, 1'b0));
    issue(16'h8000, 16'h0001, mk(16'h7FFF, 1'b0, 1'b1));
    issue(16'h7FFF, 16'hFFFF, mk(16'h8000, 1'b1, 1'b1));
    issue(16'hFFFF, 16'h8000, mk(16'h7FFF, 1'b0, 1'b0));
    wait_drain();

    // Start held high with operands changing every cycle
    period_on = 1'b1;
    for (int i = 0; i < 30; i++) begin
      x = 16'h1111 * 16'(i) + 16'h0123;
      y = 16'h0F0F ^ 16'(i * 16'h0301);
      a = x;
      b = y;
      start = 1'b1;
      if (!busy) begin
        e = ref_sub(x, y);
        e.acc = cyc + 1;
        sbq.push_back(e);
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain();
    period_on = 1'b0;

    // Reset during RUN slice 2 aborts the operation
    issue(16'h8000, 16'h0001, mk(16'h7FFF, 1'b0, 1'b1));
    wait_drain();
    issue(16'h5555, 16'h1111, mk(16'h4444, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    abort = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {16'd0, diff}, 32'd0);
    chk("abort_borrow", {31'd0, borrow}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", {31'd0, done}, 32'd0);
    end
    issue(16'hABCD, 16'h1234, mk(16'h9999, 1'b0, 1'b0));
    wait_drain();

    // Random operand pairs against the reference a-b
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      issue(x, y, ref_sub(x, y));
    end
    wait_drain();
    repeat (3) @(negedge clk);
    chk("queue_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
